// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, FSM encoding and byte-enable patterns for mem_access_ctrl.
// Alignment helper is used only when MEM_ALIGN_EXC_EN is defined.
package mem_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic [3:0] byte_en(input logic [5:0] op,
                                           input logic [1:0] a);
        logic [3:0] be;
        be = BE_NONE;
        unique case (op)
            OP_SB: begin
                unique case (a)
                    2'd0: be = BE_B0;
                    2'd1: be = BE_B1;
                    2'd2: be = BE_B2;
                    default: be = BE_B3;
                endcase
            end
            OP_SH:   be = a[1] ? BE_H_HI : BE_H_LO;
            OP_SW:   be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] op,
                                               input logic [31:0] wd);
        logic [31:0] d;
        d = 32'h0;
        unique case (op)
            OP_SB:   d = {4{wd[7:0]}};
            OP_SH:   d = {2{wd[15:0]}};
            OP_SW:   d = wd;
            default: d = 32'h0;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input logic [5:0] op,
                                        input logic [1:0] a);
        logic m;
        m = 1'b0;
        unique case (op)
            OP_LH, OP_LHU, OP_SH: m = a[0];
            OP_LW, OP_SW:         m = |a;
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load lane select and sign/zero extension; purely combinational.
module load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[{addr, 3'b000} +: 8];
        h    = addr[1] ? rdata[31:16] : rdata[15:0];
        data = rdata;
        unique case (opcode)
            OP_LB:   data = {{24{b[7]}}, b};
            OP_LBU:  data = {24'h0, b};
            OP_LH:   data = {{16{h[15]}}, h};
            OP_LHU:  data = {16'h0, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: IDLE -> REQ -> DONE handshake.
// Define MEM_ALIGN_EXC_EN to trap misaligned ops on Addr_Exc instead of issuing them.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] WriteData_M,
    input  logic [31:0] Mem_RData,
    input  logic        Mem_Ack,
    output logic        Stall_M,
    output logic        Mem_Req,
    output logic        Mem_WE,
    output logic [31:0] Mem_Addr,
    output logic [3:0]  Mem_BE,
    output logic [31:0] Mem_WData,
    output logic [31:0] Load_Data_W,
    output logic        Load_Valid
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic        Addr_Exc
`endif
);

    state_t      state;
    logic [5:0]  op;
    logic [5:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic        mem_op;
    logic        mis;
    logic [31:0] ext_data;
    logic        unused_bits;

    assign op          = Instr_M[31:26];
    assign mem_op      = is_load(op) | is_store(op);
    assign unused_bits = ^Instr_M[25:0];

`ifdef MEM_ALIGN_EXC_EN
    assign mis = mem_op & misaligned(op, ALU_Out_M[1:0]);
`else
    assign mis = 1'b0;
`endif

    // DONE releases the pipeline so the op is not reissued.
    assign Stall_M = mem_op & ~mis & (state != ST_DONE);

    load_ext u_load_ext (
        .opcode (op_q),
        .addr   (addr_lo_q),
        .rdata  (Mem_RData),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= 6'h0;
            addr_lo_q   <= 2'b00;
            Mem_Req     <= 1'b0;
            Mem_WE      <= 1'b0;
            Mem_Addr    <= 32'h0;
            Mem_BE      <= BE_NONE;
            Mem_WData   <= 32'h0;
            Load_Data_W <= 32'h0;
            Load_Valid  <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
            Addr_Exc    <= 1'b0;
`endif
        end else begin
            Load_Valid <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
            Addr_Exc   <= mis;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (mem_op && !mis) begin
                        op_q      <= op;
                        addr_lo_q <= ALU_Out_M[1:0];
                        Mem_Addr  <= {ALU_Out_M[31:2], 2'b00};
                        Mem_BE    <= byte_en(op, ALU_Out_M[1:0]);
                        Mem_WData <= store_data(op, WriteData_M);
                        Mem_WE    <= is_store(op);
                        Mem_Req   <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (Mem_Ack) begin
                        Mem_Req <= 1'b0;
                        Mem_WE  <= 1'b0;
                        if (is_load(op_q)) begin
                            Load_Data_W <= ext_data;
                            Load_Valid  <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus multi-cycle sequences.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_load;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_M;
    logic [31:0] ALU_Out_M;
    logic [31:0] WriteData_M;
    logic [31:0] Mem_RData;
    logic        Mem_Ack;
    logic        Stall_M;
    logic        Mem_Req;
    logic        Mem_WE;
    logic [31:0] Mem_Addr;
    logic [3:0]  Mem_BE;
    logic [31:0] Mem_WData;
    logic [31:0] Load_Data_W;
    logic        Load_Valid;
`ifdef MEM_ALIGN_EXC_EN
    logic        Addr_Exc;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vt[12];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .Instr_M     (Instr_M),
        .ALU_Out_M   (ALU_Out_M),
        .WriteData_M (WriteData_M),
        .Mem_RData   (Mem_RData),
        .Mem_Ack     (Mem_Ack),
        .Stall_M     (Stall_M),
        .Mem_Req     (Mem_Req),
        .Mem_WE      (Mem_WE),
        .Mem_Addr    (Mem_Addr),
        .Mem_BE      (Mem_BE),
        .Mem_WData   (Mem_WData),
        .Load_Data_W (Load_Data_W),
        .Load_Valid  (Load_Valid)
`ifdef MEM_ALIGN_EXC_EN
        ,
        .Addr_Exc    (Addr_Exc)
`endif
    );

    function automatic vec_t mk(logic [5:0] op, logic [31:0] addr,
                                logic [31:0] wd, logic [31:0] rdata,
                                logic [31:0] e_addr, logic [3:0] e_be,
                                logic [31:0] e_wdata, logic e_we,
                                logic [31:0] e_load);
        vec_t v;
        v.op = op; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_we = e_we; v.e_load = e_load;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr(logic [5:0] op);
        return {op, 26'h1234567};
    endfunction

    task automatic do_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        Instr_M = instr(v.op); ALU_Out_M = v.addr; WriteData_M = v.wd;
        #1;
        check({s, " stall_idle"}, 32'(Stall_M), 32'd1);
        tick();
        check({s, " req"},   32'(Mem_Req),  32'd1);
        check({s, " we"},    32'(Mem_WE),   32'(v.e_we));
        check({s, " addr"},  Mem_Addr,      v.e_addr);
        check({s, " be"},    32'(Mem_BE),   32'(v.e_be));
        if (v.e_we)
            check({s, " wdata"}, Mem_WData, v.e_wdata);
        check({s, " stall_req"}, 32'(Stall_M), 32'd1);
        Mem_Ack = 1'b1; Mem_RData = v.rdata;
        tick();
        Mem_Ack = 1'b0; Mem_RData = 32'h0;
        #1;
        check({s, " stall_done"}, 32'(Stall_M), 32'd0);
        check({s, " req_done"},   32'(Mem_Req), 32'd0);
        check({s, " lvalid"},     32'(Load_Valid), 32'(!v.e_we));
        if (!v.e_we)
            check({s, " ldata"}, Load_Data_W, v.e_load);
        Instr_M = 32'h0;
        tick();
        check({s, " lvalid_end"}, 32'(Load_Valid), 32'd0);
    endtask

    initial begin
        int stall_cnt;

        vt[0]  = mk(OP_SB,  32'h13,  32'hAB,       32'h0,
                    32'h10, 4'b1000, 32'hABABABAB, 1'b1, 32'h0);
        vt[1]  = mk(OP_SB,  32'h100, 32'h12345678, 32'h0,
                    32'h100, 4'b0001, 32'h78787878, 1'b1, 32'h0);
        vt[2]  = mk(OP_SH,  32'h2,   32'h1234,     32'h0,
                    32'h0,  4'b1100, 32'h12341234, 1'b1, 32'h0);
        vt[3]  = mk(OP_SH,  32'h20,  32'hDEADBEEF, 32'h0,
                    32'h20, 4'b0011, 32'hBEEFBEEF, 1'b1, 32'h0);
        vt[4]  = mk(OP_SW,  32'h44,  32'hCAFEF00D, 32'h0,
                    32'h44, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0);
        vt[5]  = mk(OP_LB,  32'h1,   32'h0,        32'h000080FF,
                    32'h0,  4'b0000, 32'h0, 1'b0, 32'hFFFFFF80);
        vt[6]  = mk(OP_LBU, 32'h1,   32'h0,        32'h000080FF,
                    32'h0,  4'b0000, 32'h0, 1'b0, 32'h00000080);
        vt[7]  = mk(OP_LH,  32'h6,   32'h0,        32'h80017FFF,
                    32'h4,  4'b0000, 32'h0, 1'b0, 32'hFFFF8001);
        vt[8]  = mk(OP_LHU, 32'h6,   32'h0,        32'h80017FFF,
                    32'h4,  4'b0000, 32'h0, 1'b0, 32'h00008001);
        vt[9]  = mk(OP_LW,  32'h8,   32'h0,        32'h89ABCDEF,
                    32'h8,  4'b0000, 32'h0, 1'b0, 32'h89ABCDEF);
        vt[10] = mk(OP_LB,  32'h3,   32'h0,        32'h7F000000,
                    32'h0,  4'b0000, 32'h0, 1'b0, 32'h0000007F);
        vt[11] = mk(OP_LH,  32'h0,   32'h0,        32'h1234F00D,
                    32'h0,  4'b0000, 32'h0, 1'b0, 32'hFFFFF00D);

        reset = 1'b1; Instr_M = 32'h0; ALU_Out_M = 32'h0;
        WriteData_M = 32'h0; Mem_RData = 32'h0; Mem_Ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst req",    32'(Mem_Req),    32'd0);
        check("rst we",     32'(Mem_WE),     32'd0);
        check("rst be",     32'(Mem_BE),     32'd0);
        check("rst addr",   Mem_Addr,        32'h0);
        check("rst wdata",  Mem_WData,       32'h0);
        check("rst ldata",  Load_Data_W,     32'h0);
        check("rst lvalid", 32'(Load_Valid), 32'd0);
        check("rst stall",  32'(Stall_M),    32'd0);
`ifdef MEM_ALIGN_EXC_EN
        check("rst exc",    32'(Addr_Exc),   32'd0);
`endif

        // non-memory op with a stray ack in IDLE
        tick();
        Instr_M = instr(6'b001000); ALU_Out_M = 32'h13; Mem_Ack = 1'b1;
        #1;
        check("nonmem stall", 32'(Stall_M), 32'd0);
        tick();
        Mem_Ack = 1'b0;
        check("nonmem req",    32'(Mem_Req),    32'd0);
        check("idle ack lval", 32'(Load_Valid), 32'd0);
        Instr_M = 32'h0;
        tick();

        for (int i = 0; i < 12; i++) do_vec(vt[i], i);

        // SH with ack on third REQ cycle; Load_Data_W must hold
        Instr_M = instr(OP_SH); ALU_Out_M = 32'h2; WriteData_M = 32'h1234;
        stall_cnt = 0;
        #1;
        if (Stall_M) stall_cnt++;
        tick();
        for (int k = 1; k <= 3; k++) begin
            check("sh3 req",   32'(Mem_Req),  32'd1);
            check("sh3 be",    32'(Mem_BE),   32'hC);
            check("sh3 wdata", Mem_WData,     32'h12341234);
            if (Stall_M) stall_cnt++;
            if (k == 3) Mem_Ack = 1'b1;
            tick();
        end
        Mem_Ack = 1'b0;
        #1;
        check("sh3 stall_cnt", stall_cnt,       32'd4);
        check("sh3 stall_done", 32'(Stall_M),   32'd0);
        check("sh3 lvalid",    32'(Load_Valid), 32'd0);
        check("sh3 ldata_hold", Load_Data_W,    32'hFFFFF00D);
        Instr_M = 32'h0;
        tick();

        // reset mid-REQ, then a late ack
        Instr_M = instr(OP_LW); ALU_Out_M = 32'h8;
        tick();
        check("rreq req", 32'(Mem_Req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; Instr_M = 32'h0;
        Mem_Ack = 1'b1; Mem_RData = 32'h12345678;
        #1;
        check("rreq req_drop", 32'(Mem_Req),     32'd0);
        check("rreq ldata",    Load_Data_W,      32'h0);
        tick();
        Mem_Ack = 1'b0;
        check("rreq req2",   32'(Mem_Req),    32'd0);
        check("rreq lvalid", 32'(Load_Valid), 32'd0);
        tick();
        check("rreq lvalid2", 32'(Load_Valid), 32'd0);
        check("rreq ldata2",  Load_Data_W,     32'h0);

`ifdef MEM_ALIGN_EXC_EN
        Instr_M = instr(OP_LW); ALU_Out_M = 32'h6;
        #1;
        check("mis stall", 32'(Stall_M), 32'd0);
        tick();
        Instr_M = 32'h0;
        check("mis exc", 32'(Addr_Exc), 32'd1);
        check("mis req", 32'(Mem_Req),  32'd0);
        tick();
        check("mis exc_end", 32'(Addr_Exc), 32'd0);
        check("mis req_end", 32'(Mem_Req),  32'd0);
`else
        do_vec(mk(OP_LW, 32'h6, 32'h0, 32'hA5A55A5A,
                  32'h4, 4'b0000, 32'h0, 1'b0, 32'hA5A55A5A), 99);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning (clock and reset first).
  clk  in  1  single system clock; all state updates on its rising edge
  reset  in  1  synchronous, active-high reset
  Instr_M  in  32  M-stage instruction; opcode = [31:26]
  ALU_Out_M  in  32  M-stage effective byte address
  WriteData_M  in  32  M-stage store data, rt value
  Mem_RData  in  32  data-memory read word
  Mem_Ack  in  1  data-memory completion strobe, one cycle
  Stall_M  out  1  freeze F/D/E/M stages
  Mem_Req  out  1  memory request, registered
  Mem_WE  out  1  write request
  Mem_Addr  out  32  word address {addr[31:2],2'b00}
  Mem_BE  out  4  byte enables
  Mem_WData  out  32  lane-replicated store data
  Load_Data_W  out  32  extended load result
  Load_Valid  out  1  Load_Data_W valid, one-cycle pulse
  Addr_Exc  out  1  misalignment pulse; present only with MEM_ALIGN_EXC_EN
REQ-002 SHALL use one clock and a synchronous, active-high reset, as fixed above.

Function
REQ-003 SHALL decode memory ops: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011; all other opcodes are non-memory ops.
REQ-004 SHALL implement FSM IDLE, REQ, DONE.
REQ-005 IDLE: on a memory op, SHALL latch address, BE, WData and opcode, then go to REQ; otherwise stay in IDLE.
REQ-006 REQ: SHALL hold Mem_Req=1 and keep all Mem_* outputs stable until Mem_Ack=1, then go to DONE.
REQ-007 DONE: SHALL go unconditionally to IDLE; the pipeline advances in this cycle, so the same instruction is never reissued.
REQ-008 Stall_M SHALL be combinational: 1 when a memory op is in M and state != DONE; 0 otherwise.
REQ-009 Byte enables SHALL be: SB -> one-hot on addr[1:0] (00->0001, 01->0010, 10->0100, 11->1000); SH -> addr[1] ? 1100 : 0011; SW -> 1111; loads -> 0000 with Mem_WE=0.
REQ-010 Mem_WData SHALL be: SB -> {4{wd[7:0]}}; SH -> {2{wd[15:0]}}; SW -> wd.
REQ-011 On Mem_Ack for a load, SHALL select the byte or halfword lane by the latched addr; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-012 The extended load result SHALL be registered into Load_Data_W, with Load_Valid=1 in the DONE cycle only.
REQ-013 Mem_Ack SHALL be ignored in IDLE and DONE.
REQ-014 Stores SHALL NOT assert Load_Valid; Load_Data_W SHALL hold its last value.
REQ-015 Minimum latency: a memory op with Ack in the first REQ cycle stalls 2 cycles.

Reset
REQ-016 On reset, SHALL set state=IDLE and Mem_Req=0, Mem_WE=0, Mem_BE=0, Mem_Addr=0, Mem_WData=0, Load_Data_W=0, Load_Valid=0, Addr_Exc=0.
REQ-017 Reset during REQ SHALL drop Mem_Req on the next edge and SHALL discard any subsequent Ack.

Configuration
REQ-018 With macro MEM_ALIGN_EXC_EN defined:
  - Misaligned ops are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0.
  - A misaligned op SHALL issue no request, stay in IDLE, hold Stall_M=0, and pulse Addr_Exc for 1 cycle.
REQ-019 Without MEM_ALIGN_EXC_EN:
  - The Addr_Exc port SHALL be absent.
  - Unused low address bits SHALL be ignored: halfword ops use addr[1] only; word ops ignore addr[1:0].

Structure
REQ-020 Shared package mem_ctrl_pkg SHALL hold the opcode constants, the FSM state encoding and the BE patterns.
REQ-021 Load extension SHALL be a sub-module load_ext (combinational: opcode, addr[1:0], rdata -> data).

Verification
REQ-022 SB addr 0x00000013, wd 0x000000AB -> Mem_BE=1000, Mem_WData=0xABABABAB, Mem_WE=1, Mem_Addr=0x00000010.
REQ-023 SH addr 0x2, wd 0x00001234, Ack after 3 REQ cycles -> Mem_BE=1100, Mem_WData=0x12341234, Stall_M high 4 cycles then low in DONE.
REQ-024 LB addr 0x1, RData 0x000080FF -> Load_Data_W=0xFFFFFF80, Load_Valid 1-cycle pulse; LBU same inputs -> 0x00000080.
REQ-025 Reset asserted mid-REQ, Ack arrives 1 cycle after reset -> Mem_Req=0, state IDLE, no Load_Valid.
REQ-026 With MEM_ALIGN_EXC_EN, LW addr 0x6 -> Mem_Req stays 0, Addr_Exc one pulse, Stall_M=0.
